// File: rtl/fact_alu_sequencer.sv
// -----------------------------------------------------------------------------
// fact_alu_sequencer
//
// Computes n! by steering a shared, purely combinational 16-bit ALU one
// operation per cycle. Only three ALU ops are used:
//   COMP  (0000) : alu_result[0] = (alu_a > alu_b), unsigned
//   DECRE (0100) : alu_result    = alu_a - 1
//   MUL   (1010) : alu_result    = (alu_a * alu_b)[WIDTH-1:0]
// The sequencer owns the accumulator (acc) and the down-counter (cnt). The
// ALU result is captured at the end of the cycle in which the op is issued.
//
// Flow per request:
//   IDLE -> LOAD -> CMP -> (MUL -> DEC -> CMP)* -> DONE -> IDLE
//   An out-of-range n goes straight IDLE -> DONE with err set.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous, active-low reset
//   start       in   request, accepted only while ready=1
//   n_in        in   operand n, sampled when start is accepted
//   ready       out  high in IDLE only
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse while in DONE
//   err         out  n_in > MAX_N; held until the next accepted start
//   result      out  n! (registered); held until the next accepted start
//   alu_sel     out  ALU op code, combinational from state
//   alu_a       out  ALU operand A
//   alu_b       out  ALU operand B
//   alu_result  in   ALU mux output for the op issued this cycle
// -----------------------------------------------------------------------------
module fact_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int MAX_N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [3:0]       OP_COMP  = 4'b0000;
  localparam logic [3:0]       OP_DECRE = 4'b0100;
  localparam logic [3:0]       OP_MUL   = 4'b1010;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_N_W  = WIDTH'(MAX_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_MUL,
    S_DEC,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] result_nx;
  logic             done_nx;
  logic             err_nx;

  // Anything above MAX_N would overflow the WIDTH-bit result.
  function automatic logic n_in_range(input logic [WIDTH-1:0] n);
    return (n <= MAX_N_W);
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      done   <= done_nx;
      err    <= err_nx;
    end
  end

  // Next-state, register updates and ALU drive
  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    result_nx = result;
    err_nx    = err;
    done_nx   = 1'b0;
    alu_sel   = OP_COMP;
    alu_a     = '0;
    alu_b     = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (n_in_range(n_in)) begin
            cnt_nx   = n_in;
            err_nx   = 1'b0;
            state_nx = S_LOAD;
          end else begin
            err_nx    = 1'b1;
            result_nx = '0;
            done_nx   = 1'b1;
            state_nx  = S_DONE;
          end
        end
      end

      S_LOAD: begin
        acc_nx   = ONE;
        state_nx = S_CMP;
      end

      // Loop while cnt > 1; n=0 and n=1 therefore exit with acc=1 untouched.
      S_CMP: begin
        alu_sel = OP_COMP;
        alu_a   = cnt;
        alu_b   = ONE;
        if (alu_result[0]) begin
          state_nx = S_MUL;
        end else begin
          result_nx = acc;
          done_nx   = 1'b1;
          state_nx  = S_DONE;
        end
      end

      S_MUL: begin
        alu_sel  = OP_MUL;
        alu_a    = acc;
        alu_b    = cnt;
        acc_nx   = alu_result;
        state_nx = S_DEC;
      end

      S_DEC: begin
        alu_sel  = OP_DECRE;
        alu_a    = cnt;
        cnt_nx   = alu_result;
        state_nx = S_CMP;
      end

      // start is deliberately not looked at here; a held start is taken
      // in the following IDLE cycle.
      S_DONE: begin
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign ready = (state == S_IDLE);
  assign busy  = ~ready;

endmodule
